// File: rtl/branch_predict_if.sv
// Predict/resolve bundle between the pipeline and the branch predict unit.
// The pipeline drives the master side; the unit sits on the slave side.
interface branch_predict_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  pred_pc;
    logic             pred_taken;
    logic             res_valid;
    logic [XLEN-1:0]  res_pc;
    logic [1:0]       br_sel;
    logic [XLEN-1:0]  alu_result;
    logic             res_pred_taken;
    logic [XLEN-1:0]  res_target;
    logic [XLEN-1:0]  res_fallthru;
    logic             take_branch;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output pred_pc, res_valid, res_pc, br_sel, alu_result,
               res_pred_taken, res_target, res_fallthru,
        input  pred_taken, take_branch, mispredict, redirect_pc, mispredict_cnt
    );

    modport slave (
        input  pred_pc, res_valid, res_pc, br_sel, alu_result,
               res_pred_taken, res_target, res_fallthru,
        output pred_taken, take_branch, mispredict, redirect_pc, mispredict_cnt
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch resolution plus bimodal 2-bit BHT prediction; a misprediction produces a
// registered one-cycle redirect and bumps a saturating mispredict counter.
module branch_predict_unit #(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 64,
    parameter int PRED_MODE = 1,
    parameter int CNT_W     = 16
) (
    input logic              clk,
    input logic              rst_n,
    branch_predict_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [1:0]       bht [ENTRIES];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             is_zero;
    logic             take;
    logic             mis;
    logic             unused_pc_bits;

    assign pred_idx = bus.pred_pc[IDX_W+1:2];
    assign res_idx  = bus.res_pc[IDX_W+1:2];
    assign is_zero  = (bus.alu_result == '0);

    // Only the index bits of each PC take part; keep lint quiet about the rest.
    assign unused_pc_bits = ^{bus.pred_pc[XLEN-1:IDX_W+2], bus.pred_pc[1:0],
                              bus.res_pc[XLEN-1:IDX_W+2], bus.res_pc[1:0]};

    always_comb begin
        take = 1'b0;
        if (bus.res_valid) begin
            case (bus.br_sel)
                2'b00:   take = 1'b0;
                2'b01:   take = 1'b1;
                2'b10:   take = is_zero;
                default: take = !is_zero;
            endcase
        end
    end

    assign bus.take_branch = take;
    // Non-branches count too: a stale taken prediction on one must still redirect.
    assign mis = bus.res_valid && (take != bus.res_pred_taken);

    generate
        if (PRED_MODE == 0) begin : g_static
            assign bus.pred_taken = 1'b0;
        end else begin : g_bimodal
            // No bypass: a same-cycle update to this index shows up next cycle.
            assign bus.pred_taken = bht[pred_idx][1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (PRED_MODE != 0 && bus.res_valid && bus.br_sel[1]) begin
            if (take) begin
                if (bht[res_idx] != 2'b11) bht[res_idx] <= bht[res_idx] + 2'd1;
            end else begin
                if (bht[res_idx] != 2'b00) bht[res_idx] <= bht[res_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.mispredict     <= 1'b0;
            bus.redirect_pc    <= '0;
            bus.mispredict_cnt <= '0;
        end else begin
            bus.mispredict <= mis;
            if (mis) begin
                bus.redirect_pc <= take ? bus.res_target : bus.res_fallthru;
                if (bus.mispredict_cnt != '1) begin
                    bus.mispredict_cnt <= bus.mispredict_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Random and directed stimulus against a bimodal instance and a static, 2-bit-counter
// instance, both checked against an arithmetic model of the predictor.
module tb_branch_predict_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pred_pc, res_pc, alu_result, res_target, res_fallthru;
    logic        res_valid, res_pred_taken;
    logic [1:0]  br_sel;

    int checks = 0;
    int failures = 0;

    int          bht [64];
    int          cnt_a, cnt_b;
    logic        exp_mp;
    logic [31:0] exp_rpc;

    always #5 clk = ~clk;

    branch_predict_if #(.XLEN(32), .CNT_W(16)) bus_a ();
    branch_predict_if #(.XLEN(32), .CNT_W(2))  bus_b ();

    assign bus_a.pred_pc = pred_pc;         assign bus_b.pred_pc = pred_pc;
    assign bus_a.res_valid = res_valid;     assign bus_b.res_valid = res_valid;
    assign bus_a.res_pc = res_pc;           assign bus_b.res_pc = res_pc;
    assign bus_a.br_sel = br_sel;           assign bus_b.br_sel = br_sel;
    assign bus_a.alu_result = alu_result;   assign bus_b.alu_result = alu_result;
    assign bus_a.res_pred_taken = res_pred_taken;
    assign bus_b.res_pred_taken = res_pred_taken;
    assign bus_a.res_target = res_target;   assign bus_b.res_target = res_target;
    assign bus_a.res_fallthru = res_fallthru;
    assign bus_b.res_fallthru = res_fallthru;

    branch_predict_unit #(.XLEN(32), .ENTRIES(64), .PRED_MODE(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    branch_predict_unit #(.XLEN(32), .ENTRIES(64), .PRED_MODE(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) bht[i] = 1;
        cnt_a = 0;
        cnt_b = 0;
        exp_mp = 1'b0;
        exp_rpc = '0;
    endtask

    // One cycle: apply inputs at negedge, check comb outputs, clock, check state.
    task automatic step(input logic rn, input logic vld, input logic [31:0] ppc,
                        input logic [31:0] rpc, input logic [1:0] sel,
                        input logic [31:0] alu, input logic rpred,
                        input logic [31:0] tgt, input logic [31:0] ft);
        logic tk, m;
        int   ri;
        rst_n = rn; res_valid = vld; pred_pc = ppc; res_pc = rpc; br_sel = sel;
        alu_result = alu; res_pred_taken = rpred; res_target = tgt; res_fallthru = ft;
        #1;
        tk = vld && (sel == 2'd1 || (sel == 2'd2 && alu == 0) || (sel == 2'd3 && alu != 0));
        m  = vld && (tk != rpred);
        chk("take_a", {31'b0, bus_a.take_branch}, {31'b0, tk});
        chk("take_b", {31'b0, bus_b.take_branch}, {31'b0, tk});
        chk("pred_a", {31'b0, bus_a.pred_taken}, (bht[ppc[7:2]] >= 2) ? 32'd1 : 32'd0);
        chk("pred_b", {31'b0, bus_b.pred_taken}, 32'd0);
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            exp_mp = m;
            if (m) begin
                exp_rpc = tk ? tgt : ft;
                cnt_a = (cnt_a < 65535) ? cnt_a + 1 : 65535;
                cnt_b = (cnt_b < 3) ? cnt_b + 1 : 3;
            end
            if (vld && sel >= 2'd2) begin
                ri = int'(rpc[7:2]);
                bht[ri] = tk ? ((bht[ri] < 3) ? bht[ri] + 1 : 3)
                             : ((bht[ri] > 0) ? bht[ri] - 1 : 0);
            end
        end
        #1;
        chk("mp_a", {31'b0, bus_a.mispredict}, {31'b0, exp_mp});
        chk("mp_b", {31'b0, bus_b.mispredict}, {31'b0, exp_mp});
        chk("rpc_a", bus_a.redirect_pc, exp_rpc);
        chk("rpc_b", bus_b.redirect_pc, exp_rpc);
        chk("cnt_a", {16'b0, bus_a.mispredict_cnt}, cnt_a);
        chk("cnt_b", {30'b0, bus_b.mispredict_cnt}, cnt_b);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rpc, ppc, alu;
        logic        rpred;
        model_reset();
        rst_n = 1'b0; res_valid = 1'b0; pred_pc = '0; res_pc = '0; br_sel = 2'd0;
        alu_result = '0; res_pred_taken = 1'b0; res_target = '0; res_fallthru = '0;
        @(negedge clk);
        step(1'b0, 1'b1, 32'h0, 32'h0, 2'd1, 32'h0, 1'b0, 32'h55, 32'h4);
        for (int i = 0; i < 64; i++) begin
            pred_pc = i * 4;
            #1;
            chk("rst_pred", {31'b0, bus_a.pred_taken}, 32'd0);
        end
        @(negedge clk);

        // Training on one conditional branch: 01 -> 10 -> 11 -> 11.
        for (int k = 0; k < 3; k++)
            step(1'b1, 1'b1, 32'h40, 32'h40, 2'd2, 32'h0, 1'b0, 32'h200, 32'h44);
        // Jump predicted not-taken, then not-taken recovery.
        step(1'b1, 1'b1, 32'h40, 32'h80, 2'd1, 32'h7, 1'b0, 32'h1000, 32'h84);
        step(1'b1, 1'b1, 32'h80, 32'h80, 2'd3, 32'h0, 1'b1, 32'h2000, 32'h84);
        // Aliasing: 0x100 and 0x0 share an index; predict sees the old counter.
        step(1'b1, 1'b1, 32'h100, 32'h0, 2'd2, 32'h0, 1'b0, 32'h300, 32'h4);
        step(1'b1, 1'b1, 32'h100, 32'h0, 2'd2, 32'h0, 1'b0, 32'h300, 32'h4);
        step(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 32'h0, 1'b1, 32'h300, 32'h4);
        // Non-branch predicted taken must redirect to fall-through.
        step(1'b1, 1'b1, 32'h0, 32'h10, 2'd0, 32'h0, 1'b1, 32'h400, 32'h14);

        for (int n = 0; n < 2000; n++) begin
            rpc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2)
                  | 32'($urandom_range(0, 3));
            ppc = ($urandom_range(0, 1) == 1) ? rpc : $urandom;
            alu = ($urandom_range(0, 1) == 1) ? 32'h0 : $urandom;
            rpred = ($urandom_range(0, 1) == 1) ? (bht[rpc[7:2]] >= 2) : 1'($urandom);
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0), ppc, rpc,
                 2'($urandom), alu, rpred, $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
